// File: rtl/qmfir_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// qmfir_mem_arb_pkg
//  Shared definitions for the QMFIR memory arbiter: default RAM geometry,
//  default starvation limit and the encoding of a captured host operation.
//  No ports; imported by qmfir_mem_arb.
// -----------------------------------------------------------------------------
package qmfir_mem_arb_pkg;

    localparam int AW_DEF         = 13;
    localparam int DW_DEF         = 24;
    localparam int STARVE_LIM_DEF = 16;

    // Kind of host access held in the capture register
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } host_op_e;

    // A simultaneous write and read pulse is treated as a write
    function automatic host_op_e decode_host_op(input logic we);
        return we ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/qmfir_mem_arb.sv
// -----------------------------------------------------------------------------
// qmfir_mem_arb
//  Shares one single-port synchronous RAM between the FIR datapath (fixed
//  priority) and the UART host port. Host pulses are captured and held until
//  served; a starvation counter forces one host slot after STARVE_LIM
//  consecutive cycles of being blocked by fir_req. Host read data is returned
//  in a holding register with a one-cycle host_rvalid pulse.
//
//  Ports
//   clk, arst_n                  clock, asynchronous active-low reset
//   fir_req/we/addr/wdata        FIR request (level, held until fir_gnt)
//   fir_gnt                      FIR access performed this cycle
//   fir_rvalid, fir_rdata        FIR read data, cycle after a granted read
//   host_we/re/addr/wdata        host access pulses (1 cycle)
//   host_busy                    host access pending or read in flight
//   host_rvalid, host_rdata      host read completion pulse / held data
//   host_ovf, host_ovf_clr       sticky dropped-pulse flag and its clear
//   mem_en/we/addr/wdata/rdata   RAM port (read latency 1 cycle)
// -----------------------------------------------------------------------------
module qmfir_mem_arb
    import qmfir_mem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic          clk,
    input  logic          arst_n,

    input  logic          fir_req,
    input  logic          fir_we,
    input  logic [AW-1:0] fir_addr,
    input  logic [DW-1:0] fir_wdata,
    output logic          fir_gnt,
    output logic          fir_rvalid,
    output logic [DW-1:0] fir_rdata,

    input  logic          host_we,
    input  logic          host_re,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_busy,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          host_ovf,
    input  logic          host_ovf_clr,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic          pend;
    host_op_e      op;
    logic [AW-1:0] op_addr;
    logic [DW-1:0] op_wdata;
    logic [CW-1:0] wait_cnt;
    logic          rd_host;
    logic          fir_rd_q;

    logic          host_pulse;
    logic          capture;
    logic          host_sel;

    assign host_pulse = host_we | host_re;
    assign host_busy  = pend | rd_host | host_rvalid;
    assign capture    = host_pulse & ~host_busy;

    // The host wins the slot whenever FIR is idle, or once it has been
    // blocked for the full starvation window
    assign host_sel   = pend & (~fir_req | (wait_cnt == LIM));
    assign fir_gnt    = fir_req & ~host_sel;

    assign fir_rvalid = fir_rd_q;
    assign fir_rdata  = mem_rdata;

    always_comb begin
        mem_en    = host_sel | fir_req;
        mem_we    = 1'b0;
        mem_addr  = fir_addr;
        mem_wdata = fir_wdata;
        if (host_sel) begin
            mem_we    = (op == OP_WRITE);
            mem_addr  = op_addr;
            mem_wdata = op_wdata;
        end else if (fir_req) begin
            mem_we    = fir_we;
        end
    end

    // Capture register: only loaded when the port is idle, so a pending
    // access can never be overwritten by a later pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend     <= 1'b0;
            op       <= OP_READ;
            op_addr  <= '0;
            op_wdata <= '0;
        end else if (capture) begin
            pend     <= 1'b1;
            op       <= decode_host_op(host_we);
            op_addr  <= host_addr;
            op_wdata <= host_wdata;
        end else if (host_sel) begin
            pend     <= 1'b0;
        end
    end

    // Counts cycles a pending host access loses to FIR; never passes LIM
    // because reaching LIM forces host_sel, which clears it
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wait_cnt <= '0;
        end else if (host_sel || !pend) begin
            wait_cnt <= '0;
        end else if (fir_req) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Read pipelines: RAM data arrives the cycle after the slot; host data
    // is then registered so it holds until the next host read completes
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_host     <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            fir_rd_q    <= 1'b0;
        end else begin
            rd_host     <= host_sel & (op == OP_READ);
            host_rvalid <= rd_host;
            fir_rd_q    <= fir_gnt & ~fir_we;
            if (rd_host) begin
                host_rdata <= mem_rdata;
            end
        end
    end

    // Sticky overflow; a clear in the same cycle as a drop leaves it clear
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            host_ovf <= 1'b0;
        end else if (host_ovf_clr) begin
            host_ovf <= 1'b0;
        end else if (host_pulse && host_busy) begin
            host_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qmfir_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_qmfir_mem_arb
//  Self-checking bench for qmfir_mem_arb with a behavioural single-port RAM.
//  Expected read data is queued when a read is issued and compared when the
//  DUT reports it (host_rvalid / fir_rvalid).
// -----------------------------------------------------------------------------
module tb_qmfir_mem_arb;

    localparam int AW = 13;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          fir_req = 1'b0, fir_we = 1'b0;
    logic [AW-1:0] fir_addr = '0;
    logic [DW-1:0] fir_wdata = 24'hDEAD00;
    logic          fir_gnt, fir_rvalid;
    logic [DW-1:0] fir_rdata;
    logic          host_we = 1'b0, host_re = 1'b0, host_ovf_clr = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_busy, host_rvalid, host_ovf;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] host_q[$];
    logic [DW-1:0] fir_q[$];

    // RAM model: unwritten locations read back a fixed address pattern
    logic [DW-1:0] ram [0:(1<<AW)-1];
    bit            written [0:(1<<AW)-1];
    logic          preload_en = 1'b0;
    logic [AW-1:0] preload_addr = '0;
    logic [DW-1:0] preload_data = '0;

    always #5 clk = ~clk;

    qmfir_mem_arb #(.AW(AW), .DW(DW), .STARVE_LIM(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .fir_req(fir_req), .fir_we(fir_we), .fir_addr(fir_addr),
        .fir_wdata(fir_wdata), .fir_gnt(fir_gnt), .fir_rvalid(fir_rvalid),
        .fir_rdata(fir_rdata),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_busy(host_busy),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_ovf(host_ovf), .host_ovf_clr(host_ovf_clr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {a[11:0] ^ 12'h3C5, a[11:0]};
    endfunction

    always @(posedge clk) begin
        if (preload_en) begin
            ram[preload_addr]     <= preload_data;
            written[preload_addr] <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? ram[mem_addr] : pattern(mem_addr);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock cycle of stimulus; returns mid-cycle so combinational and
    // registered outputs of that cycle can be checked
    task automatic applyStimulus(input logic we, input logic re,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic ovf_clr, input logic freq,
                                 input logic [AW-1:0] faddr);
        @(posedge clk);
        #1;
        host_we      = we;
        host_re      = re;
        host_addr    = addr;
        host_wdata   = wdata;
        host_ovf_clr = ovf_clr;
        fir_req      = freq;
        fir_we       = 1'b0;
        fir_addr     = faddr;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0);
    endtask

    // Read-data monitor: FIR data must follow a granted read by exactly one
    // cycle; every host_rvalid must match the oldest outstanding host read
    logic prev_fir_rd = 1'b0;
    always @(negedge clk) begin
        if (!arst_n) begin
            prev_fir_rd = 1'b0;
        end else begin
            checkOutput("fir_rvalid_timing", {31'd0, fir_rvalid}, {31'd0, prev_fir_rd});
            if (fir_rvalid) begin
                if (fir_q.size() == 0) checkOutput("fir_rvalid_unexp", 1, 0);
                else checkOutput("fir_rdata", {8'd0, fir_rdata}, {8'd0, fir_q.pop_front()});
            end
            if (host_rvalid) begin
                if (host_q.size() == 0) checkOutput("host_rvalid_unexp", 1, 0);
                else checkOutput("host_rdata", {8'd0, host_rdata}, {8'd0, host_q.pop_front()});
            end
            prev_fir_rd = fir_gnt & ~fir_we;
        end
    end

    initial begin
        int            nogrant_cnt;
        int            nogrant_at;
        logic [AW-1:0] faddr;

        // Reset state
        idle(2);
        checkOutput("rst_busy",   {31'd0, host_busy},   0);
        checkOutput("rst_rvalid", {31'd0, host_rvalid}, 0);
        checkOutput("rst_ovf",    {31'd0, host_ovf},    0);
        checkOutput("rst_rdata",  {8'd0, host_rdata},   0);
        checkOutput("rst_mem_en", {31'd0, mem_en},      0);
        arst_n = 1'b1;
        idle(2);

        // 1: host write with idle FIR
        $display("[TB] host write, idle FIR");
        applyStimulus(1, 0, 13'h0123, 24'hA5A5A5, 0, 0, '0);
        checkOutput("t1_busy_c0",  {31'd0, host_busy}, 0);
        checkOutput("t1_mem_en_c0", {31'd0, mem_en},   0);
        idle(1);
        checkOutput("t1_mem_we",    {31'd0, mem_we},   1);
        checkOutput("t1_mem_addr",  {19'd0, mem_addr}, 32'h0123);
        checkOutput("t1_mem_wdata", {8'd0, mem_wdata}, 32'hA5A5A5);
        checkOutput("t1_busy_c1",   {31'd0, host_busy}, 1);
        idle(1);
        checkOutput("t1_busy_c2",   {31'd0, host_busy}, 0);

        // 2: host read of a preloaded word
        $display("[TB] host read latency");
        @(posedge clk); #1;
        preload_en = 1'b1; preload_addr = 13'h0123; preload_data = 24'h5A5A5A;
        @(posedge clk); #1;
        preload_en = 1'b0;
        applyStimulus(0, 1, 13'h0123, '0, 0, 0, '0);
        host_q.push_back(24'h5A5A5A);
        idle(1);
        checkOutput("t2_mem_rd",   {31'd0, mem_en & ~mem_we}, 1);
        checkOutput("t2_rv_c1",    {31'd0, host_rvalid}, 0);
        idle(1);
        checkOutput("t2_rv_c2",    {31'd0, host_rvalid}, 0);
        checkOutput("t2_busy_c2",  {31'd0, host_busy},   1);
        idle(1);
        checkOutput("t2_rv_c3",    {31'd0, host_rvalid}, 1);
        checkOutput("t2_busy_c3",  {31'd0, host_busy},   1);
        idle(1);
        checkOutput("t2_rv_c4",    {31'd0, host_rvalid}, 0);
        checkOutput("t2_busy_c4",  {31'd0, host_busy},   0);
        idle(4);
        checkOutput("t2_rdata_hold", {8'd0, host_rdata}, 32'h5A5A5A);

        // 3: starvation with FIR reading continuously
        $display("[TB] starvation slot under continuous FIR reads");
        nogrant_cnt = 0;
        nogrant_at  = -1;
        faddr       = 13'h0100;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(0, (k == 0), 13'h0200, '0, 0, 1, faddr);
            if (k == 0) host_q.push_back(pattern(13'h0200));
            if (fir_gnt) begin
                fir_q.push_back(pattern(faddr));
                faddr = faddr + 13'd1;
            end else begin
                nogrant_cnt++;
                nogrant_at = k;
                checkOutput("t3_slot_addr", {19'd0, mem_addr}, 32'h0200);
                checkOutput("t3_slot_we",   {31'd0, mem_we},   0);
            end
        end
        checkOutput("t3_nogrant_cnt", nogrant_cnt, 1);
        checkOutput("t3_nogrant_at",  nogrant_at,  17);
        idle(4);

        // 4: dropped pulse sets overflow; clear has priority over a set
        $display("[TB] overflow flag");
        applyStimulus(1, 0, 13'h0300, 24'h111111, 0, 0, '0);
        applyStimulus(0, 1, 13'h0123, '0, 0, 0, '0);
        checkOutput("t4_ovf_c1",   {31'd0, host_ovf},  0);
        checkOutput("t4_mem_addr", {19'd0, mem_addr},  32'h0300);
        checkOutput("t4_mem_we",   {31'd0, mem_we},    1);
        idle(1);
        checkOutput("t4_ovf_c2",   {31'd0, host_ovf},  1);
        checkOutput("t4_busy_c2",  {31'd0, host_busy}, 0);
        idle(3);
        checkOutput("t4_ovf_sticky", {31'd0, host_ovf}, 1);
        applyStimulus(0, 0, '0, '0, 1, 0, '0);
        idle(1);
        checkOutput("t4_ovf_cleared", {31'd0, host_ovf}, 0);
        applyStimulus(1, 0, 13'h0301, 24'h333333, 0, 0, '0);
        applyStimulus(1, 0, 13'h0304, 24'h444444, 1, 0, '0);
        idle(1);
        checkOutput("t4_clr_wins", {31'd0, host_ovf}, 0);
        idle(2);

        // 5: host served when FIR idle, FIR granted immediately after
        $display("[TB] host slot then FIR grant");
        applyStimulus(1, 0, 13'h0302, 24'h222222, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, '0);
        checkOutput("t5_host_we",   {31'd0, mem_we},   1);
        checkOutput("t5_host_addr", {19'd0, mem_addr}, 32'h0302);
        checkOutput("t5_no_fgnt",   {31'd0, fir_gnt},  0);
        applyStimulus(0, 0, '0, '0, 0, 1, 13'h0105);
        checkOutput("t5_fgnt",      {31'd0, fir_gnt},  1);
        checkOutput("t5_fir_addr",  {19'd0, mem_addr}, 32'h0105);
        if (fir_gnt) fir_q.push_back(pattern(13'h0105));
        idle(2);
        applyStimulus(0, 1, 13'h0300, '0, 0, 0, '0);
        host_q.push_back(24'h111111);
        idle(5);

        // 6: asynchronous reset during a host read in flight
        $display("[TB] reset during host read");
        applyStimulus(0, 1, 13'h0301, '0, 0, 0, '0);
        applyStimulus(1, 0, 13'h0305, 24'h555555, 0, 0, '0);
        applyStimulus(0, 0, '0, '0, 0, 0, '0);
        checkOutput("t6_ovf_before", {31'd0, host_ovf},  1);
        checkOutput("t6_busy_before", {31'd0, host_busy}, 1);
        arst_n = 1'b0;
        #1;
        checkOutput("t6_busy_rst",  {31'd0, host_busy},   0);
        checkOutput("t6_ovf_rst",   {31'd0, host_ovf},    0);
        checkOutput("t6_rv_rst",    {31'd0, host_rvalid}, 0);
        checkOutput("t6_rdata_rst", {8'd0, host_rdata},   0);
        idle(2);
        arst_n = 1'b1;
        idle(5);
        checkOutput("t6_busy_after", {31'd0, host_busy}, 0);
        applyStimulus(0, 1, 13'h0302, '0, 0, 0, '0);
        host_q.push_back(24'h222222);
        idle(6);

        checkOutput("host_q_drained", host_q.size(), 0);
        checkOutput("fir_q_drained",  fir_q.size(),  0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
